// File: rtl/nios2_debug_pkg.sv
// rtl/nios2_debug_pkg.sv - shared constants and FSM encoding for the debug monitor RAM controller
// Purpose: jdo field offsets, data width and the ocimem controller state encoding.
// Ports: none (package).
package nios2_debug_pkg;

    localparam int DATA_W       = 32;
    localparam int JDO_W        = 38;
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_DATA_MSB = 34;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        JWR      = 3'd1,
        JRD      = 3'd2,
        JRD_DATA = 3'd3,
        CPU_WR   = 3'd4,
        CPU_RD   = 3'd5,
        CPU_ACK  = 3'd6
    } ocimem_state_t;

endpackage

// File: rtl/nios2_debug_ocimem_ram.sv
// rtl/nios2_debug_ocimem_ram.sv - single-port synchronous monitor RAM with byte-enable write
// Purpose: 2**ADDR_W x 32 storage, read-first, registered read data (1-cycle latency).
// Ports: clk; addr word address; we write strobe; be byte lanes; wdata write data; q read data.
module nios2_debug_ocimem_ram
    import nios2_debug_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/nios2_debug_ocimem_ctrl.sv
// rtl/nios2_debug_ocimem_ctrl.sv - arbitrates JTAG debug commands and CPU Avalon-MM accesses to the monitor RAM
// Purpose: JTAG loads MonAReg, writes and reads words (auto-increment); CPU reaches the same RAM.
// Ports: clk, reset_n (async active-low); jdo + take_action_ocimem_a/_b, take_no_action_ocimem_a
//        command pulses; MonDReg JTAG read result; jtag_busy; avs_* CPU slave port;
//        wr_err sticky blocked-write flag (only with OCIMEM_ROM_PROTECT_EN).
// Configuration: OCIMEM_ROM_PROTECT_EN makes the upper half read-only to non-debug CPU writes.
module nios2_debug_ocimem_ctrl
    import nios2_debug_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [3:0]        avs_byteenable,
    input  logic              avs_debugaccess,
    output logic [DATA_W-1:0] avs_readdata,
`ifdef OCIMEM_ROM_PROTECT_EN
    output logic              avs_waitrequest,
    output logic              wr_err
`else
    output logic              avs_waitrequest
`endif
);

    if (RD_LAT != 1 || ADDR_W < 4 || ADDR_W > 18) begin : g_param_check
        $error("nios2_debug_ocimem_ctrl: unsupported RD_LAT/ADDR_W");
    end

    ocimem_state_t     state;
    logic [ADDR_W-1:0] mon_a_reg;
    logic [ADDR_W-1:0] mon_a_cur;
    logic              pend_wr;
    logic              pend_rd;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_hold;
    logic              cpu_ack;
    logic              free;
    logic              wr_req;
    logic              rd_req;
    logic              grant_jwr;
    logic              grant_jrd;
    logic              grant_cwr;
    logic              grant_crd;
    logic              cpu_wr_ok;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;
    logic              unused_bits;

    assign unused_bits = ^{jdo[JDO_W-1:JDO_DATA_MSB+1], jdo[JDO_DATA_LSB-1:0], avs_debugaccess};

`ifdef OCIMEM_ROM_PROTECT_EN
    assign cpu_wr_ok = ~(avs_address[ADDR_W-1] & ~avs_debugaccess);
`else
    assign cpu_wr_ok = 1'b1;
`endif

    // Address as it stands after this cycle's load/increment; a JTAG write granted in the
    // same cycle as a load or a finishing auto-increment must already target it.
    always_comb begin
        mon_a_cur = mon_a_reg;
        if (take_action_ocimem_a) begin
            mon_a_cur = jdo[JDO_ADDR_LSB +: ADDR_W];
        end else if (state == JWR || state == JRD_DATA) begin
            mon_a_cur = mon_a_reg + ADDR_W'(1);
        end
    end

    // The RAM port is free in IDLE and in the last cycle of a JTAG op, so arbitration runs
    // there too; this keeps a JTAG write ahead of a waiting CPU write to a single extra cycle.
    // Incoming pulses count as requests so a same-cycle CPU request cannot jump ahead.
    assign free      = state inside {IDLE, JWR, JRD_DATA};
    assign wr_req    = take_action_ocimem_b    | (pend_wr & (state != JWR));
    assign rd_req    = take_no_action_ocimem_a | (pend_rd & (state != JRD_DATA));
    assign grant_jwr = free & wr_req;
    assign grant_jrd = free & ~wr_req & rd_req;
    assign grant_cwr = free & ~wr_req & ~rd_req & avs_write;
    assign grant_crd = free & ~wr_req & ~rd_req & ~avs_write & avs_read;

    // Writes land on the grant edge; reads present the address on the grant edge (CPU) or
    // in JRD (JTAG).
    always_comb begin
        ram_addr  = mon_a_reg;
        ram_we    = 1'b0;
        ram_be    = 4'hF;
        ram_wdata = avs_writedata;
        if (grant_jwr) begin
            ram_addr  = mon_a_cur;
            ram_we    = 1'b1;
            ram_wdata = take_action_ocimem_b ? jdo[JDO_DATA_MSB:JDO_DATA_LSB] : wr_data;
        end else if (grant_cwr) begin
            ram_addr = avs_address;
            ram_we   = cpu_wr_ok;
            ram_be   = avs_byteenable;
        end else if (grant_crd) begin
            ram_addr = avs_address;
        end
    end

    nios2_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mon_a_reg <= '0;
            MonDReg   <= '0;
            pend_wr   <= 1'b0;
            pend_rd   <= 1'b0;
            wr_data   <= '0;
            rd_hold   <= '0;
            cpu_ack   <= 1'b0;
`ifdef OCIMEM_ROM_PROTECT_EN
            wr_err    <= 1'b0;
`endif
        end else begin
            mon_a_reg <= mon_a_cur;
            cpu_ack   <= grant_cwr | grant_crd;

            if (take_action_ocimem_b) begin
                pend_wr <= 1'b1;
                wr_data <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
            end else if (state == JWR) begin
                pend_wr <= 1'b0;
            end

            if (take_no_action_ocimem_a) begin
                pend_rd <= 1'b1;
            end else if (state == JRD_DATA) begin
                pend_rd <= 1'b0;
            end

            if (state == JRD_DATA) begin
                MonDReg <= ram_q;
            end
            if (state == CPU_RD) begin
                rd_hold <= ram_q;
            end
`ifdef OCIMEM_ROM_PROTECT_EN
            if (grant_cwr && !cpu_wr_ok) begin
                wr_err <= 1'b1;
            end
`endif

            case (state)
                IDLE, JWR, JRD_DATA: begin
                    if (grant_jwr)      state <= JWR;
                    else if (grant_jrd) state <= JRD;
                    else if (grant_cwr) state <= CPU_WR;
                    else if (grant_crd) state <= CPU_RD;
                    else                state <= IDLE;
                end
                JRD:     state <= JRD_DATA;
                default: state <= IDLE;
            endcase
        end
    end

    // CPU_WR/CPU_RD are the acknowledge cycles; read data comes straight from the RAM
    // output then and is held afterwards.
    assign avs_readdata    = (state == CPU_RD) ? ram_q : rd_hold;
    assign avs_waitrequest = (avs_read | avs_write) & ~cpu_ack;
    assign jtag_busy       = pend_wr | pend_rd | (state inside {JWR, JRD, JRD_DATA});

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// tb/tb_nios2_debug_ocimem_ctrl.sv - directed scoreboard bench for nios2_debug_ocimem_ctrl
module tb_nios2_debug_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic [7:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = 4'hF;
    logic        avs_debugaccess = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
`ifdef OCIMEM_ROM_PROTECT_EN
    logic        wr_err;
`endif

    always #5 clk = ~clk;

    nios2_debug_ocimem_ctrl #(.ADDR_W(8), .RD_LAT(1)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_debugaccess         (avs_debugaccess),
        .avs_readdata            (avs_readdata),
`ifdef OCIMEM_ROM_PROTECT_EN
        .avs_waitrequest         (avs_waitrequest),
        .wr_err                  (wr_err)
`else
        .avs_waitrequest         (avs_waitrequest)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [256];
    bit          known [256];
    logic [7:0]  mon_a = '0;
    logic [31:0] exp_cpu [$];
    logic [31:0] exp_jtag [$];
    int          waits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit blocked(input logic [7:0] a, input bit dbg);
`ifdef OCIMEM_ROM_PROTECT_EN
        return a[7] & ~dbg;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [37:0] mk_addr(input logic [7:0] a);
        return {13'b0, a, 17'b0};
    endfunction

    function automatic logic [37:0] mk_data(input logic [31:0] d);
        return {3'b0, d, 3'b0};
    endfunction

    task automatic model_store(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
        end
        if (be == 4'hF) known[a] = 1'b1;
    endtask

    task automatic wait_ack(input string tag, output int n);
        bit done = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (avs_waitrequest) n++;
            else done = 1'b1;
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                             input bit dbg, input string tag);
        int n;
        @(posedge clk); #1;
        avs_address = a; avs_writedata = d; avs_byteenable = be;
        avs_debugaccess = dbg; avs_write = 1'b1;
        if (!blocked(a, dbg)) model_store(a, d, be);
        wait_ack(tag, n);
        check({tag, "_waits"}, n, 32'd1);
        @(posedge clk); #1;
        avs_write = 1'b0; avs_debugaccess = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, input string tag);
        int n;
        bit k;
        @(posedge clk); #1;
        avs_address = a; avs_read = 1'b1;
        k = known[a];
        if (k) exp_cpu.push_back(model[a]);
        wait_ack(tag, n);
        check({tag, "_waits"}, n, 32'd1);
        if (k) check({tag, "_data"}, avs_readdata, exp_cpu.pop_front());
        @(posedge clk); #1;
        avs_read = 1'b0;
    endtask

    task automatic jtag(input bit a_p, input bit b_p, input bit rd_p, input logic [37:0] j);
        @(posedge clk); #1;
        jdo = j;
        take_action_ocimem_a = a_p;
        take_action_ocimem_b = b_p;
        take_no_action_ocimem_a = rd_p;
        if (a_p) mon_a = j[24:17];
        if (b_p) begin
            model_store(mon_a, j[34:3], 4'hF);
            mon_a++;
        end
        if (rd_p) begin
            exp_jtag.push_back(model[mon_a]);
            mon_a++;
        end
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_jtag(input string tag, input bit pop);
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!jtag_busy) done = 1'b1;
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
        if (pop) check(tag, MonDReg, exp_jtag.pop_front());
    endtask

    initial begin
        for (int i = 0; i < 256; i++) known[i] = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_mondreg", MonDReg, 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        check("rst_busy", {31'd0, jtag_busy}, 32'd0);
        check("rst_waitreq", {31'd0, avs_waitrequest}, 32'd0);
`ifdef OCIMEM_ROM_PROTECT_EN
        check("rst_wr_err", {31'd0, wr_err}, 32'd0);
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;

        // first CPU read after reset: one wait cycle, JTAG side untouched
        cpu_read(8'h10, "rd_0x10");
        check("mondreg_after_cpu_rd", MonDReg, 32'd0);
        cpu_write(8'h00, 32'hA5A5_0001, 4'hF, 1'b0, "wr_0x00");

        // JTAG write at top address, reload, read back, then read after wrap
        jtag(1'b1, 1'b0, 1'b0, mk_addr(8'hFF));
        jtag(1'b0, 1'b1, 1'b0, mk_data(32'hDEAD_BEEF));
        wait_jtag("jwr_ff", 1'b0);
        jtag(1'b1, 1'b0, 1'b0, mk_addr(8'hFF));
        jtag(1'b0, 1'b0, 1'b1, 38'd0);
        check("jrd_busy", {31'd0, jtag_busy}, 32'd1);
        wait_jtag("jrd_ff", 1'b1);
        jtag(1'b0, 1'b0, 1'b1, 38'd0);
        wait_jtag("jrd_wrap_00", 1'b1);
        cpu_read(8'hFF, "rd_0xff");

        // byte-enable merge
        cpu_write(8'h20, 32'hFFFF_FFFF, 4'hF, 1'b0, "wr_0x20_full");
        cpu_write(8'h20, 32'h1234_5678, 4'b0011, 1'b0, "wr_0x20_be");
        cpu_read(8'h20, "rd_0x20");

        // JTAG write and CPU write issued in the same cycle
        jtag(1'b1, 1'b0, 1'b0, mk_addr(8'h40));
        @(posedge clk); #1;
        avs_address = 8'h41; avs_writedata = 32'h0BAD_F00D; avs_byteenable = 4'hF;
        avs_write = 1'b1;
        jdo = mk_data(32'h1357_9BDF);
        take_action_ocimem_b = 1'b1;
        model_store(8'h40, 32'h1357_9BDF, 4'hF);
        mon_a++;
        model_store(8'h41, 32'h0BAD_F00D, 4'hF);
        waits = 0;
        @(negedge clk);
        if (avs_waitrequest) waits++;
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
        begin
            int n;
            wait_ack("contend", n);
            waits += n;
        end
        check("contend_waits", waits, 32'd2);
        @(posedge clk); #1;
        avs_write = 1'b0;
        cpu_read(8'h40, "rd_0x40_jtag");
        cpu_read(8'h41, "rd_0x41_cpu");
        jtag(1'b0, 1'b0, 1'b1, 38'd0);
        wait_jtag("jrd_0x41", 1'b1);

        // reset while a JTAG read is in its data cycle
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        mon_a = '0;
        @(negedge clk);
        check("midrst_mondreg", MonDReg, 32'd0);
        check("midrst_busy", {31'd0, jtag_busy}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        cpu_read(8'h20, "rd_after_rst");
        jtag(1'b0, 1'b0, 1'b1, 38'd0);
        wait_jtag("jrd_after_rst", 1'b1);

        // upper-half writes with and without debugaccess
        cpu_write(8'h80, 32'h1111_1111, 4'hF, 1'b1, "wr_0x80_dbg");
        cpu_write(8'h80, 32'h2222_2222, 4'hF, 1'b0, "wr_0x80_nodbg");
        cpu_read(8'h80, "rd_0x80_a");
`ifdef OCIMEM_ROM_PROTECT_EN
        check("wr_err_set", {31'd0, wr_err}, 32'd1);
`endif
        cpu_write(8'h80, 32'h3333_3333, 4'hF, 1'b1, "wr_0x80_dbg2");
        cpu_read(8'h80, "rd_0x80_b");
        jtag(1'b1, 1'b0, 1'b0, mk_addr(8'h81));
        jtag(1'b0, 1'b1, 1'b0, mk_data(32'h4444_4444));
        wait_jtag("jwr_0x81", 1'b0);
        cpu_read(8'h81, "rd_0x81");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
